// File: rtl/square_wave_meter.sv
// rtl/square_wave_meter.sv - measures high time, low time and period of an external square wave
module square_wave_meter #(
  parameter int COUNT_WIDTH = 24
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Signal_in,
  output logic [COUNT_WIDTH-1:0] High_count,
  output logic [COUNT_WIDTH-1:0] Low_count,
  output logic [COUNT_WIDTH:0]   Period_count,
  output logic                   Result_valid,
  input  logic                   Result_ready,
  output logic                   Overrun,
  output logic                   Timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] SEG_MAX = '1;

  logic                   s1, s2, s3;
  logic [2:0]             primed;
  logic                   rise, fall, seg_sat;
  logic [COUNT_WIDTH-1:0] seg;
  logic [COUNT_WIDTH-1:0] hi_tmp;
  state_t                 state, state_nxt;
  logic                   latch_hi, complete, abort;

  // Synchronizer, edge history, and a marker of which stages hold real pin samples
  // (reset values are not observations, so IDLE must not treat them as a low level).
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      primed <= 3'b000;
    end else begin
      s1     <= Signal_in;
      s2     <= s1;
      s3     <= s2;
      primed <= {primed[1:0], 1'b1};
    end
  end

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign seg_sat = (seg == SEG_MAX);

  // Segment counter: restarts at 1 on every edge, saturates when the level lasts too long.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      seg <= '0;
    end else if (rise || fall) begin
      seg <= {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (!seg_sat) begin
      seg <= seg + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: arm on a genuine low level, then track high/low segments.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (primed[2] && !s2) state_nxt = ARMED;
      ARMED: if (rise) state_nxt = HIGH;
      HIGH: begin
        if (fall)         state_nxt = LOW;
        else if (seg_sat) state_nxt = IDLE;
      end
      LOW: begin
        if (rise)         state_nxt = HIGH;
        else if (seg_sat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: capture high time, complete a period, or abort on saturation.
  always_comb begin
    latch_hi = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state)
      HIGH: begin
        latch_hi = fall;
        abort    = !fall && seg_sat;
      end
      LOW: begin
        complete = rise;
        abort    = !rise && seg_sat;
      end
      default: ;
    endcase
  end

  // High segment holding register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      hi_tmp <= '0;
    end else if (latch_hi) begin
      hi_tmp <= seg;
    end
  end

  // Result registers and handshake; a pending result is never overwritten.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      High_count   <= '0;
      Low_count    <= '0;
      Period_count <= '0;
      Result_valid <= 1'b0;
      Overrun      <= 1'b0;
      Timeout      <= 1'b0;
    end else begin
      if (complete) begin
        if (!Result_valid || Result_ready) begin
          High_count   <= hi_tmp;
          Low_count    <= seg;
          Period_count <= {1'b0, hi_tmp} + {1'b0, seg};
          Result_valid <= 1'b1;
          Overrun      <= 1'b0;
          Timeout      <= 1'b0;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (Result_valid && Result_ready) begin
        Result_valid <= 1'b0;
      end
      if (abort) begin
        Timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_square_wave_meter.sv
// tb/tb_square_wave_meter.sv - directed self-checking bench for square_wave_meter
module tb_square_wave_meter;

  logic        clock;
  logic        reset_n;
  logic        signal_in;
  logic        result_ready;
  logic [23:0] high_count;
  logic [23:0] low_count;
  logic [24:0] period_count;
  logic        result_valid;
  logic        overrun;
  logic        timeout;

  logic        signal_in_b;
  logic        result_ready_b;
  logic [3:0]  high_count_b;
  logic [3:0]  low_count_b;
  logic [4:0]  period_count_b;
  logic        result_valid_b;
  logic        overrun_b;
  logic        timeout_b;

  int compared   = 0;
  int mismatched = 0;

  square_wave_meter #(.COUNT_WIDTH(24)) dut (
    .Clock        (clock),
    .Reset_n      (reset_n),
    .Signal_in    (signal_in),
    .High_count   (high_count),
    .Low_count    (low_count),
    .Period_count (period_count),
    .Result_valid (result_valid),
    .Result_ready (result_ready),
    .Overrun      (overrun),
    .Timeout      (timeout)
  );

  square_wave_meter #(.COUNT_WIDTH(4)) dut_small (
    .Clock        (clock),
    .Reset_n      (reset_n),
    .Signal_in    (signal_in_b),
    .High_count   (high_count_b),
    .Low_count    (low_count_b),
    .Period_count (period_count_b),
    .Result_valid (result_valid_b),
    .Result_ready (result_ready_b),
    .Overrun      (overrun_b),
    .Timeout      (timeout_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic level, input int n);
    signal_in = level;
    repeat (n) tick();
  endtask

  task automatic drive_b(input logic level, input int n);
    signal_in_b = level;
    repeat (n) tick();
  endtask

  // Rising edge that completes a period; result expected 3 clocks after the edge is first sampled.
  task automatic rise_check(input string tag, input int h, input int eh, input int el, input bit lat);
    signal_in = 1'b1;
    tick();
    tick();
    if (lat) check({tag, "_lat"}, {31'd0, result_valid}, 32'd0);
    tick();
    check({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
    check({tag, "_hi"}, {8'd0, high_count}, eh);
    check({tag, "_lo"}, {8'd0, low_count}, el);
    check({tag, "_per"}, {7'd0, period_count}, eh + el);
    repeat (h - 3) tick();
  endtask

  initial begin
    reset_n        = 1'b0;
    signal_in      = 1'b0;
    result_ready   = 1'b1;
    signal_in_b    = 1'b0;
    result_ready_b = 1'b1;
    repeat (3) tick();
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_hi", {8'd0, high_count}, 32'd0);
    check("rst_lo", {8'd0, low_count}, 32'd0);
    check("rst_per", {7'd0, period_count}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_tmo", {31'd0, timeout}, 32'd0);
    reset_n = 1'b1;

    // Basic 5/5 wave, first high only arms the measurement
    drive(1'b0, 5);
    drive(1'b1, 5);
    check("arm_no_result", {31'd0, result_valid}, 32'd0);
    drive(1'b0, 5);
    rise_check("basic1", 5, 5, 5, 1'b1);
    drive(1'b0, 5);
    rise_check("basic2", 5, 5, 5, 1'b1);
    drive(1'b0, 5);

    // Asymmetric 3/7 duty
    rise_check("basic3", 3, 5, 5, 1'b1);
    drive(1'b0, 7);
    rise_check("asym1", 3, 3, 7, 1'b1);
    drive(1'b0, 1);
    check("valid_clear", {31'd0, result_valid}, 32'd0);
    drive(1'b0, 6);

    // Backpressure across two completions
    result_ready = 1'b0;
    rise_check("bp1", 5, 3, 7, 1'b1);
    drive(1'b0, 5);
    rise_check("bp2_hold", 5, 3, 7, 1'b0);
    check("bp2_ovr", {31'd0, overrun}, 32'd1);
    drive(1'b0, 2);
    check("bp_hold_hi", {8'd0, high_count}, 32'd3);
    result_ready = 1'b1;
    drive(1'b0, 3);
    check("bp_drain", {31'd0, result_valid}, 32'd0);
    check("bp_ovr_sticky", {31'd0, overrun}, 32'd1);
    rise_check("bp3", 5, 5, 5, 1'b1);
    check("bp3_ovr_clr", {31'd0, overrun}, 32'd0);
    drive(1'b0, 5);

    // Reset during a high segment
    rise_check("pre_rst", 3, 5, 5, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, result_valid}, 32'd0);
    check("mid_rst_hi", {8'd0, high_count}, 32'd0);
    check("mid_rst_lo", {8'd0, low_count}, 32'd0);
    check("mid_rst_per", {7'd0, period_count}, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    drive(1'b1, 8);
    check("post_rst_partial", {31'd0, result_valid}, 32'd0);
    drive(1'b0, 6);
    drive(1'b1, 4);
    check("post_rst_arm", {31'd0, result_valid}, 32'd0);
    drive(1'b0, 6);
    rise_check("post_rst", 4, 4, 6, 1'b1);
    drive(1'b0, 4);

    // Stuck input on the 4-bit instance
    signal_in_b = 1'b1;
    repeat (17) tick();
    check("stuck_tmo_early", {31'd0, timeout_b}, 32'd0);
    tick();
    check("stuck_tmo", {31'd0, timeout_b}, 32'd1);
    check("stuck_no_valid", {31'd0, result_valid_b}, 32'd0);
    repeat (5) tick();
    drive_b(1'b0, 4);
    drive_b(1'b1, 4);
    check("stuck_tmo_sticky", {31'd0, timeout_b}, 32'd1);
    check("stuck_rearm_none", {31'd0, result_valid_b}, 32'd0);
    drive_b(1'b0, 4);
    signal_in_b = 1'b1;
    repeat (3) tick();
    check("w4_valid", {31'd0, result_valid_b}, 32'd1);
    check("w4_hi", {28'd0, high_count_b}, 32'd4);
    check("w4_lo", {28'd0, low_count_b}, 32'd4);
    check("w4_per", {27'd0, period_count_b}, 32'd8);
    check("w4_tmo_clr", {31'd0, timeout_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
